// File: rtl/sweep_run_ctrl.sv
// sweep_run_ctrl: sequences one NoC sweep run. It holds the leaf clients in
// reset, releases them, and waits for client_done. It then waits for the
// network to drain (injected == ejected) and to stay idle for QUIESCE_CYCLES.
// Underflow, counter saturation and a drain watchdog end the run in FAIL.
//
// Handshake: start is a single-cycle request with no ready. It is acted on
// only in IDLE, DONE or FAIL and is silently dropped in every other state.
// inj/ej are per-leaf single-cycle event pulses. They are counted only while
// running.
module sweep_run_ctrl #(
    parameter int N              = 8,
    parameter int CNT_W          = 32,
    parameter int RST_CYCLES     = 2,
    parameter int DRAIN_MAX      = 65536,
    parameter int QUIESCE_CYCLES = 16,
    parameter int DONE_ALL       = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     client_done,
    input  logic [N-1:0]     inj,
    input  logic [N-1:0]     ej,
    output logic             client_rst,
    output logic             running,
    output logic             done,
    output logic             fail,
    output logic [1:0]       fail_code,
    output logic [CNT_W-1:0] injected,
    output logic [CNT_W-1:0] ejected,
    output logic [CNT_W-1:0] outstanding,
    output logic [2:0]       state_dbg
);

    localparam int PW = $clog2(N + 1);
    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int DW = $clog2(DRAIN_MAX + 1);
    localparam int QW = $clog2(QUIESCE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RESET   = 3'd1,
        S_RUN     = 3'd2,
        S_DRAIN   = 3'd3,
        S_QUIESCE = 3'd4,
        S_DONE    = 3'd5,
        S_FAIL    = 3'd6
    } state_t;

    state_t           state, state_n;
    logic [RW-1:0]    rst_cnt, rst_cnt_n;
    logic [DW-1:0]    drain_t, drain_n;
    logic [QW-1:0]    quiet, quiet_n;
    logic [CNT_W-1:0] inj_n, ej_n;
    logic [1:0]       code_n;
    logic [CNT_W:0]   inj_sum, ej_sum;
    logic             counting, activity, exit_cond, run_n;

    function automatic logic [PW-1:0] popcount(input logic [N-1:0] v);
        logic [PW-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) c = c + PW'(v[i]);
        return c;
    endfunction

    assign state_dbg = state;

    // Next-state and next-counter logic; counter faults override the FSM move.
    always_comb begin
        state_n   = state;
        rst_cnt_n = rst_cnt;
        drain_n   = drain_t;
        quiet_n   = quiet;
        inj_n     = injected;
        ej_n      = ejected;
        code_n    = fail_code;
        counting  = (state == S_RUN) || (state == S_DRAIN) || (state == S_QUIESCE);
        activity  = |(inj | ej);
        exit_cond = (DONE_ALL != 0) ? (&client_done) : (|client_done);
        inj_sum   = {1'b0, injected} + (CNT_W+1)'(popcount(inj));
        ej_sum    = {1'b0, ejected} + (CNT_W+1)'(popcount(ej));

        case (state)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) begin
                    state_n   = S_RESET;
                    rst_cnt_n = '0;
                    drain_n   = '0;
                    quiet_n   = '0;
                    inj_n     = '0;
                    ej_n      = '0;
                    code_n    = 2'd0;
                end
            end
            S_RESET: begin
                if (rst_cnt == RW'(RST_CYCLES - 1)) state_n = S_RUN;
                else rst_cnt_n = rst_cnt + RW'(1);
            end
            S_RUN: begin
                if (exit_cond) state_n = S_DRAIN;
            end
            S_DRAIN: begin
                drain_n = drain_t + DW'(1);
                if (drain_n == DW'(DRAIN_MAX)) begin
                    state_n = S_FAIL;
                    code_n  = 2'd1;
                end else if (outstanding == '0 && !activity) begin
                    // The idle cycle that leaves DRAIN is the first quiet cycle.
                    quiet_n = QW'(1);
                    state_n = (QUIESCE_CYCLES == 1) ? S_DONE : S_QUIESCE;
                end
            end
            S_QUIESCE: begin
                if (activity) begin
                    state_n = S_DRAIN;
                    quiet_n = '0;
                end else begin
                    quiet_n = quiet + QW'(1);
                    if (quiet_n == QW'(QUIESCE_CYCLES)) state_n = S_DONE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (counting) begin
            if (ej_sum > inj_sum) begin
                // Leave both counters untouched so they show the last sane totals.
                state_n = S_FAIL;
                code_n  = 2'd2;
            end else if (inj_sum[CNT_W] || ej_sum[CNT_W]) begin
                inj_n   = inj_sum[CNT_W] ? '1 : inj_sum[CNT_W-1:0];
                ej_n    = ej_sum[CNT_W] ? '1 : ej_sum[CNT_W-1:0];
                state_n = S_FAIL;
                code_n  = 2'd3;
            end else begin
                inj_n = inj_sum[CNT_W-1:0];
                ej_n  = ej_sum[CNT_W-1:0];
            end
        end

        run_n = (state_n == S_RUN) || (state_n == S_DRAIN) || (state_n == S_QUIESCE);
    end

    // State, counters and all outputs are registered from the next-state values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            rst_cnt     <= '0;
            drain_t     <= '0;
            quiet       <= '0;
            injected    <= '0;
            ejected     <= '0;
            outstanding <= '0;
            fail_code   <= 2'd0;
            client_rst  <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            fail        <= 1'b0;
        end else begin
            state       <= state_n;
            rst_cnt     <= rst_cnt_n;
            drain_t     <= drain_n;
            quiet       <= quiet_n;
            injected    <= inj_n;
            ejected     <= ej_n;
            outstanding <= inj_n - ej_n;
            fail_code   <= code_n;
            client_rst  <= ~run_n;
            running     <= run_n;
            done        <= (state_n == S_DONE);
            fail        <= (state_n == S_FAIL);
        end
    end

endmodule

// File: tb/tb_sweep_run_ctrl.sv
// tb_sweep_run_ctrl: directed runs against two controllers (DONE_ALL=0 and
// DONE_ALL=1) with hand-computed expected output snapshots.
module tb_sweep_run_ctrl;

    localparam int W = 22;
    localparam int ST_IDLE = 0, ST_RESET = 1, ST_RUN = 2, ST_DRAIN = 3;
    localparam int ST_QUIESCE = 4, ST_DONE = 5, ST_FAIL = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] client_done = 4'b0000;
    logic [3:0] client_done_b = 4'b0000;
    logic [3:0] inj = 4'b0000;
    logic [3:0] ej = 4'b0000;

    logic       a_crst, a_run, a_done, a_fail;
    logic [1:0] a_code;
    logic [3:0] a_inj, a_ej, a_out;
    logic [2:0] a_st;
    logic       b_crst, b_run, b_done, b_fail;
    logic [1:0] b_code;
    logic [3:0] b_inj, b_ej, b_out;
    logic [2:0] b_st;

    int checks = 0;
    int fails = 0;
    int cyc = 0;

    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];
    string        name_q[$];

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sweep_run_ctrl #(.N(4), .CNT_W(4), .RST_CYCLES(2), .DRAIN_MAX(100),
                     .QUIESCE_CYCLES(16), .DONE_ALL(0)) dut_a (
        .clk(clk), .rst(rst), .start(start), .client_done(client_done),
        .inj(inj), .ej(ej), .client_rst(a_crst), .running(a_run), .done(a_done),
        .fail(a_fail), .fail_code(a_code), .injected(a_inj), .ejected(a_ej),
        .outstanding(a_out), .state_dbg(a_st));

    sweep_run_ctrl #(.N(4), .CNT_W(4), .RST_CYCLES(2), .DRAIN_MAX(100),
                     .QUIESCE_CYCLES(16), .DONE_ALL(1)) dut_b (
        .clk(clk), .rst(rst), .start(start), .client_done(client_done_b),
        .inj(inj), .ej(ej), .client_rst(b_crst), .running(b_run), .done(b_done),
        .fail(b_fail), .fail_code(b_code), .injected(b_inj), .ejected(b_ej),
        .outstanding(b_out), .state_dbg(b_st));

    // driver: apply one cycle of inputs, return #1 after the edge
    task automatic tick(input int s, input int i, input int e);
        start = 1'(s);
        inj   = 4'(i);
        ej    = 4'(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        inj   = 4'b0000;
        ej    = 4'b0000;
    endtask

    // scoreboard push: expected snapshot for the edge just taken
    task automatic expect_out(input int sel, input string nm, input int crst,
                              input int run, input int dn, input int fl,
                              input int code, input int ni, input int ne,
                              input int no, input int st);
        exp_q.push_back({1'(sel), 1'(crst), 1'(run), 1'(dn), 1'(fl), 2'(code),
                         4'(ni), 4'(ne), 4'(no), 3'(st)});
        exp_cyc_q.push_back(cyc);
        name_q.push_back(nm);
    endtask

    // monitor: compare every expectation tagged for the current cycle
    always @(negedge clk) begin
        logic [W-1:0] e, act;
        string nm;
        while (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            void'(exp_cyc_q.pop_front());
            if (e[W-1])
                act = {1'b1, b_crst, b_run, b_done, b_fail, b_code, b_inj, b_ej, b_out, b_st};
            else
                act = {1'b0, a_crst, a_run, a_done, a_fail, a_code, a_inj, a_ej, a_out, a_st};
            checks++;
            if (act !== e) begin
                fails++;
                $display("FAIL %s @cyc %0d: got %h required %h (sel crst run done fail code inj ej out st)",
                         nm, cyc, act, e);
            end
        end
    end

    initial begin
        // reset
        tick(0, 0, 0);
        tick(0, 0, 0);
        expect_out(0, "reset_a", 1, 0, 0, 0, 0, 0, 0, 0, ST_IDLE);
        expect_out(1, "reset_b", 1, 0, 0, 0, 0, 0, 0, 0, ST_IDLE);
        rst = 1'b0;

        // basic run: 10 injections on leaf 0, 10 ejections on leaf 3
        tick(1, 0, 0); expect_out(0, "start_reset", 1, 0, 0, 0, 0, 0, 0, 0, ST_RESET);
        tick(0, 0, 0); expect_out(0, "rst_hold", 1, 0, 0, 0, 0, 0, 0, 0, ST_RESET);
        tick(0, 0, 0); expect_out(0, "rst_release", 0, 1, 0, 0, 0, 0, 0, 0, ST_RUN);
        checks++;
        if (a_crst !== 1'b0) begin
            fails++;
            $display("FAIL direct_client_rst_low: got %b required 0", a_crst);
        end
        for (int i = 0; i < 10; i++) begin
            tick(0, 'b0001, 0);
            expect_out(0, "inj_leaf0", 0, 1, 0, 0, 0, i + 1, i, 1, ST_RUN);
            tick(0, 0, 'b1000);
            expect_out(0, "ej_leaf3", 0, 1, 0, 0, 0, i + 1, i + 1, 0, ST_RUN);
        end
        client_done = 4'b0010;
        tick(0, 0, 0); expect_out(0, "enter_drain", 0, 1, 0, 0, 0, 10, 10, 0, ST_DRAIN);
        for (int j = 1; j <= 15; j++) begin
            tick(0, 0, 0);
            if (j == 1) expect_out(0, "enter_quiesce", 0, 1, 0, 0, 0, 10, 10, 0, ST_QUIESCE);
        end
        expect_out(0, "quiesce_edge16", 0, 1, 0, 0, 0, 10, 10, 0, ST_QUIESCE);
        tick(0, 0, 0); expect_out(0, "done_edge17", 1, 0, 1, 0, 0, 10, 10, 0, ST_DONE);
        checks++;
        if (a_done !== 1'b1) begin
            fails++;
            $display("FAIL direct_done_edge17: got %b required 1", a_done);
        end
        client_done = 4'b0000;
        tick(0, 'b1111, 'b1111); expect_out(0, "done_ignores_pulses", 1, 0, 1, 0, 0, 10, 10, 0, ST_DONE);

        // simultaneous events and quiesce restart
        tick(1, 0, 0); expect_out(0, "restart_clears", 1, 0, 0, 0, 0, 0, 0, 0, ST_RESET);
        tick(0, 0, 0);
        tick(0, 0, 0);
        tick(0, 'b0111, 0); expect_out(0, "prior_inj", 0, 1, 0, 0, 0, 3, 0, 3, ST_RUN);
        tick(0, 'b1111, 'b0011); expect_out(0, "simultaneous", 0, 1, 0, 0, 0, 7, 2, 5, ST_RUN);
        tick(0, 0, 'b1111); expect_out(0, "ej4", 0, 1, 0, 0, 0, 7, 6, 1, ST_RUN);
        tick(0, 0, 'b0001); expect_out(0, "ej1", 0, 1, 0, 0, 0, 7, 7, 0, ST_RUN);
        client_done = 4'b0001;
        tick(0, 0, 0); expect_out(0, "drain2", 0, 1, 0, 0, 0, 7, 7, 0, ST_DRAIN);
        client_done = 4'b0000;
        for (int j = 1; j <= 10; j++) tick(0, 0, 0);
        expect_out(0, "quiet10", 0, 1, 0, 0, 0, 7, 7, 0, ST_QUIESCE);
        tick(0, 'b0100, 0); expect_out(0, "quiesce_to_drain", 0, 1, 0, 0, 0, 8, 7, 1, ST_DRAIN);
        tick(0, 0, 0);
        tick(0, 0, 0); expect_out(0, "drain_hold", 0, 1, 0, 0, 0, 8, 7, 1, ST_DRAIN);
        tick(0, 0, 'b0100); expect_out(0, "late_ej", 0, 1, 0, 0, 0, 8, 8, 0, ST_DRAIN);
        for (int j = 1; j <= 15; j++) tick(0, 0, 0);
        expect_out(0, "quiet15_again", 0, 1, 0, 0, 0, 8, 8, 0, ST_QUIESCE);
        tick(0, 0, 0); expect_out(0, "done_after16", 1, 0, 1, 0, 0, 8, 8, 0, ST_DONE);

        // watchdog with outstanding held at 3; also start ignored in RUN
        tick(1, 0, 0); expect_out(0, "wd_start", 1, 0, 0, 0, 0, 0, 0, 0, ST_RESET);
        tick(0, 0, 0);
        tick(0, 0, 0);
        tick(0, 'b0111, 0); expect_out(0, "wd_inj3", 0, 1, 0, 0, 0, 3, 0, 3, ST_RUN);
        tick(1, 0, 0); expect_out(0, "start_ignored_run", 0, 1, 0, 0, 0, 3, 0, 3, ST_RUN);
        client_done = 4'b0001;
        tick(0, 0, 0); expect_out(0, "wd_drain", 0, 1, 0, 0, 0, 3, 0, 3, ST_DRAIN);
        client_done = 4'b0000;
        for (int k = 1; k <= 99; k++) tick(0, 0, 0);
        expect_out(0, "wd_99", 0, 1, 0, 0, 0, 3, 0, 3, ST_DRAIN);
        tick(0, 0, 0); expect_out(0, "wd_timeout", 1, 0, 0, 1, 1, 3, 0, 3, ST_FAIL);
        checks++;
        if (a_code !== 2'd1) begin
            fails++;
            $display("FAIL direct_wd_code: got %0d required 1", a_code);
        end
        tick(0, 'b1111, 0); expect_out(0, "fail_sticky", 1, 0, 0, 1, 1, 3, 0, 3, ST_FAIL);

        // underflow
        tick(1, 0, 0); expect_out(0, "uf_start", 1, 0, 0, 0, 0, 0, 0, 0, ST_RESET);
        tick(0, 0, 0);
        tick(0, 0, 0);
        tick(0, 0, 'b0001); expect_out(0, "underflow", 1, 0, 0, 1, 2, 0, 0, 0, ST_FAIL);
        checks++;
        if (a_ej !== 4'd0) begin
            fails++;
            $display("FAIL direct_uf_ejected: got %0d required 0", a_ej);
        end

        // saturation at CNT_W=4
        tick(1, 0, 0);
        tick(0, 0, 0);
        tick(0, 0, 0);
        tick(0, 'b1111, 0); expect_out(0, "sat_4", 0, 1, 0, 0, 0, 4, 0, 4, ST_RUN);
        tick(0, 'b1111, 0); expect_out(0, "sat_8", 0, 1, 0, 0, 0, 8, 0, 8, ST_RUN);
        tick(0, 'b1111, 0); expect_out(0, "sat_12", 0, 1, 0, 0, 0, 12, 0, 12, ST_RUN);
        tick(0, 'b1111, 0); expect_out(0, "saturate", 1, 0, 0, 1, 3, 15, 0, 15, ST_FAIL);
        checks++;
        if (a_inj !== 4'd15) begin
            fails++;
            $display("FAIL direct_sat_injected: got %0d required 15", a_inj);
        end

        // reset mid-run (rst dominates start), then a fresh run on both
        tick(1, 0, 0);
        tick(0, 0, 0);
        tick(0, 0, 0);
        tick(0, 'b0011, 0); expect_out(0, "mr_inj2", 0, 1, 0, 0, 0, 2, 0, 2, ST_RUN);
        client_done = 4'b0001;
        tick(0, 0, 0); expect_out(0, "mr_drain", 0, 1, 0, 0, 0, 2, 0, 2, ST_DRAIN);
        client_done = 4'b0000;
        rst = 1'b1;
        tick(1, 'b0001, 0);
        expect_out(0, "midrun_reset_a", 1, 0, 0, 0, 0, 0, 0, 0, ST_IDLE);
        expect_out(1, "midrun_reset_b", 1, 0, 0, 0, 0, 0, 0, 0, ST_IDLE);
        rst = 1'b0;
        tick(1, 0, 0); expect_out(1, "b_start", 1, 0, 0, 0, 0, 0, 0, 0, ST_RESET);
        tick(0, 0, 0);
        tick(0, 0, 0);
        expect_out(0, "a_run_again", 0, 1, 0, 0, 0, 0, 0, 0, ST_RUN);
        expect_out(1, "b_run", 0, 1, 0, 0, 0, 0, 0, 0, ST_RUN);
        tick(0, 'b0001, 0);
        expect_out(0, "a_count_from0", 0, 1, 0, 0, 0, 1, 0, 1, ST_RUN);
        expect_out(1, "b_count_from0", 0, 1, 0, 0, 0, 1, 0, 1, ST_RUN);
        tick(0, 0, 'b0001); expect_out(1, "b_ej", 0, 1, 0, 0, 0, 1, 1, 0, ST_RUN);
        client_done = 4'b0001;
        client_done_b = 4'b0001;
        tick(0, 0, 0);
        expect_out(0, "a_any_exit", 0, 1, 0, 0, 0, 1, 1, 0, ST_DRAIN);
        expect_out(1, "b_one_bit", 0, 1, 0, 0, 0, 1, 1, 0, ST_RUN);
        client_done_b = 4'b0111;
        tick(0, 0, 0); expect_out(1, "b_three_bits", 0, 1, 0, 0, 0, 1, 1, 0, ST_RUN);
        client_done_b = 4'b1111;
        tick(0, 0, 0); expect_out(1, "b_all_bits", 0, 1, 0, 0, 0, 1, 1, 0, ST_DRAIN);
        client_done_b = 4'b0000;
        tick(0, 0, 0); expect_out(1, "b_quiesce", 0, 1, 0, 0, 0, 1, 1, 0, ST_QUIESCE);

        // let the monitor consume the last entries, then report
        @(negedge clk);
        @(negedge clk);
        while (exp_q.size() > 0) begin
            checks++;
            fails++;
            $display("FAIL unchecked_%s: got none required tag cyc %0d", name_q.pop_front(),
                     exp_cyc_q.pop_front());
            void'(exp_q.pop_front());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
